// File: rtl/pix_sram_writer_if.sv
// Pixel-in / SRAM-out bundle for pix_sram_writer.
// Pixel input is strobe-only: i_pix/i_check_code are sampled in the cycle i_pix_valid=1; there is
// no ready, so a strobe that finds the FIFO full is dropped and flagged on o_overflow.
interface pix_sram_writer_if #(
   parameter int ADDR_W = 18,
   parameter int ERR_W  = 16
);
   logic              i_start;
   logic [11:0]       i_pix;
   logic              i_pix_valid;
   logic [7:0]        i_check_code;
   logic              i_check_valid;
   logic [ADDR_W-1:0] o_sram_addr;
   logic [15:0]       o_sram_dq;
   logic              o_sram_dq_oe;
   logic              o_sram_ce_n;
   logic              o_sram_we_n;
   logic              o_sram_oe_n;
   logic              o_busy;
   logic              o_frame_done;
   logic [ADDR_W-1:0] o_pix_cnt;
   logic [ERR_W-1:0]  o_err_cnt;
   logic              o_overflow;
   logic [1:0]        o_dbg_state;

   modport master (
      output i_start, i_pix, i_pix_valid, i_check_code, i_check_valid,
      input  o_sram_addr, o_sram_dq, o_sram_dq_oe, o_sram_ce_n, o_sram_we_n, o_sram_oe_n,
      input  o_busy, o_frame_done, o_pix_cnt, o_err_cnt, o_overflow, o_dbg_state
   );
   modport slave (
      input  i_start, i_pix, i_pix_valid, i_check_code, i_check_valid,
      output o_sram_addr, o_sram_dq, o_sram_dq_oe, o_sram_ce_n, o_sram_we_n, o_sram_oe_n,
      output o_busy, o_frame_done, o_pix_cnt, o_err_cnt, o_overflow, o_dbg_state
   );
endinterface

// File: rtl/pix_sram_writer.sv
// Checks incoming pixels against their check codes, buffers them in a small FIFO and writes
// one frame of PIX_TOTAL pixels into async SRAM through a SETUP/WE/HOLD write cycle.
module pix_sram_writer #(
   parameter int ADDR_W    = 18,
   parameter int PIX_TOTAL = 76800,
   parameter int WR_CYCLES = 2,
   parameter int FIFO_AW   = 2,
   parameter int ERR_W     = 16
) (
   input logic              i_clk_sys,
   input logic              i_rst_n,
   pix_sram_writer_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WE, ST_HOLD} state_e;

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int PW    = FIFO_AW + 1;
   localparam int WC_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
   localparam logic [WC_W-1:0]   WC_LAST = WC_W'(WR_CYCLES - 1);
   localparam logic [ADDR_W-1:0] PIX_END = ADDR_W'(PIX_TOTAL);

   state_e            state_q, state_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [11:0]       dq_q, dq_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic              ovf_q, ovf_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [11:0]       mem_q [DEPTH];
   logic [11:0]       mem_d [DEPTH];

   logic       fifo_empty, fifo_full, pop, push, code_bad, last_pix;
   logic [5:0] code_exp;
   logic       unused_code_bits;

   // Check-code bits [1:0] describe pixel bits that were never transmitted.
   assign unused_code_bits = ^bus.i_check_code[1:0];

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign pop        = (state_q == ST_IDLE) && busy_q && !fifo_empty && !bus.i_start;
   assign push       = bus.i_pix_valid && busy_q && !bus.i_start && (!fifo_full || pop);
   assign code_exp   = {bus.i_pix[11], bus.i_pix[8], bus.i_pix[7],
                        bus.i_pix[4], bus.i_pix[3], bus.i_pix[0]};
   assign code_bad   = bus.i_check_valid && (code_exp != bus.i_check_code[7:2]);
   assign last_pix   = (state_q == ST_HOLD) && ((pix_cnt_q + ADDR_W'(1)) == PIX_END);

   always_ff @(posedge i_clk_sys) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         wcnt_q    <= '0;
         addr_q    <= '0;
         dq_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pix_cnt_q <= '0;
         err_cnt_q <= '0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         addr_q    <= addr_d;
         dq_q      <= dq_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pix_cnt_q <= pix_cnt_d;
         err_cnt_q <= err_cnt_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         mem_q     <= mem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      if (bus.i_start) begin
         state_d = ST_IDLE;
         wcnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE:  if (pop) state_d = ST_SETUP;
            ST_SETUP: begin
               state_d = ST_WE;
               wcnt_d  = '0;
            end
            ST_WE: begin
               if (wcnt_q == WC_LAST) state_d = ST_HOLD;
               else                   wcnt_d  = wcnt_q + WC_W'(1);
            end
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      addr_d    = addr_q;
      dq_d      = dq_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pix_cnt_d = pix_cnt_q;
      err_cnt_d = err_cnt_q;
      ovf_d     = ovf_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      mem_d     = mem_q;
      if (bus.i_start) begin
         busy_d    = 1'b1;
         addr_d    = '0;
         pix_cnt_d = '0;
         err_cnt_d = '0;
         ovf_d     = 1'b0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
      end else begin
         if (pop) begin
            dq_d     = mem_q[rd_ptr_q[FIFO_AW-1:0]];
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push) begin
            mem_d[wr_ptr_q[FIFO_AW-1:0]] = bus.i_pix;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (code_bad && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_d = err_cnt_q + ERR_W'(1);
         end else if (bus.i_pix_valid && busy_q) begin
            ovf_d = 1'b1;
         end
         if (state_q == ST_HOLD) begin
            addr_d    = addr_q + ADDR_W'(1);
            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
         end
         // Frame complete: anything still queued belongs to no frame and is discarded.
         if (last_pix) begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            addr_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
         end
      end
   end

   always_comb begin
      bus.o_sram_addr  = addr_q;
      bus.o_sram_dq    = {4'b0000, dq_q};
      bus.o_sram_dq_oe = (state_q != ST_IDLE);
      bus.o_sram_ce_n  = (state_q == ST_IDLE);
      bus.o_sram_we_n  = (state_q != ST_WE);
      bus.o_sram_oe_n  = 1'b1;
      bus.o_busy       = busy_q;
      bus.o_frame_done = done_q;
      bus.o_pix_cnt    = pix_cnt_q;
      bus.o_err_cnt    = err_cnt_q;
      bus.o_overflow   = ovf_q;
      bus.o_dbg_state  = state_q;
   end
endmodule

// File: tb/tb_pix_sram_writer.sv
// Directed bench for pix_sram_writer: instance A (4-pixel frame, 2-cycle WE) and
// instance B (8-cycle WE, 4-bit error counter) for overflow and saturation corners.
module tb_pix_sram_writer;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pix_sram_writer_if #(.ADDR_W(18), .ERR_W(16)) bus_a ();
   pix_sram_writer_if #(.ADDR_W(18), .ERR_W(4))  bus_b ();

   pix_sram_writer #(.ADDR_W(18), .PIX_TOTAL(4), .WR_CYCLES(2), .FIFO_AW(2), .ERR_W(16)) u_a (
      .i_clk_sys(clk), .i_rst_n(rst_n), .bus(bus_a));
   pix_sram_writer #(.ADDR_W(18), .PIX_TOTAL(1024), .WR_CYCLES(8), .FIFO_AW(2), .ERR_W(4)) u_b (
      .i_clk_sys(clk), .i_rst_n(rst_n), .bus(bus_b));

   logic        sel_b = 1'b0;
   logic        obs_we_n, obs_ce_n, obs_dq_oe;
   logic [17:0] obs_addr;
   logic [15:0] obs_dq;
   assign obs_we_n  = sel_b ? bus_b.o_sram_we_n  : bus_a.o_sram_we_n;
   assign obs_ce_n  = sel_b ? bus_b.o_sram_ce_n  : bus_a.o_sram_ce_n;
   assign obs_dq_oe = sel_b ? bus_b.o_sram_dq_oe : bus_a.o_sram_dq_oe;
   assign obs_addr  = sel_b ? bus_b.o_sram_addr  : bus_a.o_sram_addr;
   assign obs_dq    = sel_b ? bus_b.o_sram_dq    : bus_a.o_sram_dq;

   typedef struct {
      logic [11:0] pix;
      logic [7:0]  code;
      logic [17:0] addr;
      logic [17:0] next_addr;
      logic [15:0] err;
      logic [17:0] cnt;
      logic        last;
   } vec_t;

   vec_t        va [4];
   vec_t        vb [6];
   logic [15:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_pix(input bit b, input logic v, input logic [11:0] pix, input logic [7:0] code);
      if (b) begin
         bus_b.i_pix_valid = v; bus_b.i_check_valid = v; bus_b.i_pix = pix; bus_b.i_check_code = code;
      end else begin
         bus_a.i_pix_valid = v; bus_a.i_check_valid = v; bus_a.i_pix = pix; bus_a.i_check_code = code;
      end
   endtask

   task automatic send_pix(input bit b, input logic [11:0] pix, input logic [7:0] code);
      drive_pix(b, 1'b1, pix, code);
      @(negedge clk);
      drive_pix(b, 1'b0, 12'h000, 8'h00);
   endtask

   task automatic pulse_start(input bit b);
      if (b) bus_b.i_start = 1'b1; else bus_a.i_start = 1'b1;
      @(negedge clk);
      bus_a.i_start = 1'b0;
      bus_b.i_start = 1'b0;
   endtask

   // Follows one SRAM write on the selected instance; returns at the HOLD sample.
   task automatic observe_write(input int exp_we, input bit chk_setup,
                                input logic [17:0] exp_addr, input logic [15:0] exp_dq);
      int   n = 0;
      int   drift = 0;
      logic pre_ce_n = 1'b1;
      logic pre_oe   = 1'b0;
      while (obs_we_n !== 1'b0 && n < 60) begin
         pre_ce_n = obs_ce_n;
         pre_oe   = obs_dq_oe;
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL we_n_wait: got no write within 60 cycles expected write to %0h", exp_addr);
         return;
      end
      if (chk_setup) begin
         check("setup_ce_n", {31'd0, pre_ce_n}, 32'd0);
         check("setup_dq_oe", {31'd0, pre_oe}, 32'd1);
      end
      check("we_addr", {14'd0, obs_addr}, {14'd0, exp_addr});
      check("we_dq", {16'd0, obs_dq}, {16'd0, exp_dq});
      n = 0;
      while (obs_we_n === 1'b0 && n < 60) begin
         if (obs_addr !== exp_addr || obs_dq !== exp_dq || obs_dq_oe !== 1'b1 || obs_ce_n !== 1'b0)
            drift++;
         @(negedge clk);
         n++;
      end
      check("we_low_cycles", n, exp_we);
      check("we_bus_stable", drift, 0);
      check("hold_ce_n", {31'd0, obs_ce_n}, 32'd0);
      check("hold_addr", {14'd0, obs_addr}, {14'd0, exp_addr});
   endtask

   task automatic quiet(input int cycles, input string name);
      int lows = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (obs_ce_n !== 1'b1 || obs_we_n !== 1'b1) lows++;
      end
      check(name, lows, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      va[0] = '{12'hABC, 8'hB8, 18'd0, 18'd1, 16'd0, 18'd1, 1'b0};
      va[1] = '{12'h123, 8'h47, 18'd1, 18'd2, 16'd0, 18'd2, 1'b0};
      va[2] = '{12'hFFF, 8'hFC, 18'd2, 18'd3, 16'd0, 18'd3, 1'b0};
      va[3] = '{12'h800, 8'h00, 18'd3, 18'd0, 16'd1, 18'd4, 1'b1};
      vb[0] = '{12'h000, 8'h00, 18'd0, 18'd0, 16'd0, 18'd0, 1'b0};
      vb[1] = '{12'h0F0, 8'h30, 18'd1, 18'd0, 16'd0, 18'd0, 1'b0};
      vb[2] = '{12'hFFF, 8'hFC, 18'd2, 18'd0, 16'd0, 18'd0, 1'b0};
      vb[3] = '{12'hABC, 8'hB8, 18'd3, 18'd0, 16'd0, 18'd0, 1'b0};
      vb[4] = '{12'h123, 8'h44, 18'd4, 18'd0, 16'd0, 18'd0, 1'b0};
      vb[5] = '{12'hFFF, 8'h00, 18'd5, 18'd0, 16'd0, 18'd0, 1'b0};

      rst_n = 1'b0;
      bus_a.i_start = 1'b0;
      bus_b.i_start = 1'b0;
      drive_pix(1'b0, 1'b0, 12'h000, 8'h00);
      drive_pix(1'b1, 1'b0, 12'h000, 8'h00);
      repeat (3) @(negedge clk);

      check("rst_addr", {14'd0, bus_a.o_sram_addr}, 32'd0);
      check("rst_dq", {16'd0, bus_a.o_sram_dq}, 32'd0);
      check("rst_ctrl", {28'd0, bus_a.o_sram_dq_oe, bus_a.o_sram_ce_n, bus_a.o_sram_we_n, bus_a.o_sram_oe_n}, 32'h7);
      check("rst_status", {29'd0, bus_a.o_busy, bus_a.o_frame_done, bus_a.o_overflow}, 32'd0);
      check("rst_cnts", {bus_a.o_err_cnt, 14'd0, bus_a.o_pix_cnt[1:0]}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Frame of four pixels on A; the last one has a bad code and ends the frame.
      pulse_start(1'b0);
      check("start_busy", {31'd0, bus_a.o_busy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         send_pix(1'b0, va[i].pix, va[i].code);
         observe_write(2, 1'b1, va[i].addr, {4'h0, va[i].pix});
         @(negedge clk);
         check("pix_cnt", {14'd0, bus_a.o_pix_cnt}, {14'd0, va[i].cnt});
         check("err_cnt", {16'd0, bus_a.o_err_cnt}, {16'd0, va[i].err});
         check("next_addr", {14'd0, bus_a.o_sram_addr}, {14'd0, va[i].next_addr});
         check("frame_done", {31'd0, bus_a.o_frame_done}, {31'd0, va[i].last});
         check("busy", {31'd0, bus_a.o_busy}, {31'd0, ~va[i].last});
      end
      @(negedge clk);
      check("frame_done_pulse", {31'd0, bus_a.o_frame_done}, 32'd0);
      send_pix(1'b0, 12'h555, 8'h00);
      quiet(10, "idle_ignores_pix");
      check("idle_pix_cnt", {14'd0, bus_a.o_pix_cnt}, 32'd4);
      check("idle_err_cnt", {16'd0, bus_a.o_err_cnt}, 32'd1);

      // B: six back-to-back strobes against a long write; the sixth must be dropped.
      sel_b = 1'b1;
      pulse_start(1'b1);
      for (int k = 0; k < 5; k++) exp_q.push_back({4'h0, vb[k].pix});
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               drive_pix(1'b1, 1'b1, vb[k].pix, vb[k].code);
               @(negedge clk);
            end
            drive_pix(1'b1, 1'b0, 12'h000, 8'h00);
            check("ovf_set", {31'd0, bus_b.o_overflow}, 32'd1);
         end
         begin
            for (int k = 0; k < 5; k++) begin
               logic [15:0] exp_dq;
               exp_dq = exp_q.pop_front();
               observe_write(8, 1'b1, vb[k].addr, exp_dq);
            end
         end
      join
      quiet(20, "sixth_not_written");
      check("ovf_pix_cnt", {14'd0, bus_b.o_pix_cnt}, 32'd5);
      check("ovf_err_cnt", {28'd0, bus_b.o_err_cnt}, 32'd0);
      check("ovf_sticky", {31'd0, bus_b.o_overflow}, 32'd1);

      // B: error counter saturation.
      pulse_start(1'b1);
      check("restart_ovf", {31'd0, bus_b.o_overflow}, 32'd0);
      check("restart_cnt", {14'd0, bus_b.o_pix_cnt}, 32'd0);
      for (int k = 0; k < 14; k++) begin
         send_pix(1'b1, 12'h800, 8'h00);
         repeat (12) @(negedge clk);
      end
      check("err_14", {28'd0, bus_b.o_err_cnt}, 32'd14);
      for (int k = 0; k < 6; k++) begin
         send_pix(1'b1, 12'h800, 8'h00);
         repeat (12) @(negedge clk);
      end
      check("err_sat", {28'd0, bus_b.o_err_cnt}, 32'hF);
      check("sat_pix_cnt", {14'd0, bus_b.o_pix_cnt}, 32'd20);

      // A: abort with i_start during the second write while a third pixel is queued.
      sel_b = 1'b0;
      pulse_start(1'b0);
      send_pix(1'b0, 12'h800, 8'h00);
      drive_pix(1'b0, 1'b1, 12'hABC, 8'hB8);
      @(negedge clk);
      drive_pix(1'b0, 1'b1, 12'h123, 8'h47);
      @(negedge clk);
      drive_pix(1'b0, 1'b0, 12'h000, 8'h00);
      observe_write(2, 1'b0, 18'd0, 16'h0800);
      check("abort_pre_err", {16'd0, bus_a.o_err_cnt}, 32'd1);
      begin
         int n = 0;
         while (obs_we_n !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
         end
         check("abort_we_seen", n < 30 ? 32'd1 : 32'd0, 32'd1);
         check("abort_pre_addr", {14'd0, bus_a.o_sram_addr}, 32'd1);
      end
      bus_a.i_start = 1'b1;
      drive_pix(1'b0, 1'b1, 12'hFFF, 8'h00);
      @(negedge clk);
      bus_a.i_start = 1'b0;
      drive_pix(1'b0, 1'b0, 12'h000, 8'h00);
      check("abort_we_n", {31'd0, bus_a.o_sram_we_n}, 32'd1);
      check("abort_ce_n", {31'd0, bus_a.o_sram_ce_n}, 32'd1);
      check("abort_addr", {14'd0, bus_a.o_sram_addr}, 32'd0);
      check("abort_cnts", {bus_a.o_err_cnt, bus_a.o_pix_cnt[15:0]}, 32'd0);
      check("abort_busy", {31'd0, bus_a.o_busy}, 32'd1);
      quiet(12, "abort_fifo_empty");
      check("abort_err_after", {16'd0, bus_a.o_err_cnt}, 32'd0);

      // A: reset asserted during WE.
      pulse_start(1'b0);
      send_pix(1'b0, 12'h800, 8'h00);
      begin
         int n = 0;
         while (obs_we_n !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
         end
         check("rst_we_seen", n < 30 ? 32'd1 : 32'd0, 32'd1);
      end
      check("rst_pre_err", {16'd0, bus_a.o_err_cnt}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rstw_ctrl", {28'd0, bus_a.o_sram_dq_oe, bus_a.o_sram_ce_n, bus_a.o_sram_we_n, bus_a.o_sram_oe_n}, 32'h7);
      check("rstw_addr_dq", {bus_a.o_sram_dq, bus_a.o_sram_addr[15:0]}, 32'd0);
      check("rstw_status", {29'd0, bus_a.o_busy, bus_a.o_frame_done, bus_a.o_overflow}, 32'd0);
      check("rstw_cnts", {bus_a.o_err_cnt, bus_a.o_pix_cnt[15:0]}, 32'd0);
      quiet(8, "rstw_no_resume");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
